// File: rtl/axiline_feeder.sv
`default_nettype none
// ============================================================================
// Module   : axiline_feeder
// Brief    : Streams weights and samples into the axiline accelerator and
//            buffers its results in a 2-entry FIFO. Optional macro
//            AXILINE_FEEDER_OVF_CNT_EN adds an 8-bit dropped-result counter.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef INPUT_BITWIDTH
`define INPUT_BITWIDTH 8
`endif
`ifndef BITWIDTH
`define BITWIDTH 16
`endif
`ifndef SIZE
`define SIZE 2
`endif
`ifndef NUMBER_UNIT
`define NUMBER_UNIT 2
`endif
`ifndef LOG_NUM_CYCLE
`define LOG_NUM_CYCLE 2
`endif
`ifndef NUM_CYCLE
`define NUM_CYCLE 4
`endif

module axiline_feeder #(
    parameter int inputBitwidth = `INPUT_BITWIDTH,
    parameter int bitwidth      = `BITWIDTH,
    parameter int size          = `SIZE,
    parameter int numUnit       = `NUMBER_UNIT,
    parameter int logNumCycle   = `LOG_NUM_CYCLE,
    parameter int numCycle      = `NUM_CYCLE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic [15:0]                           num_samples,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [inputBitwidth*size*numUnit-1:0] w_data,
    input  logic                                  x_valid,
    output logic                                  x_ready,
    input  logic [inputBitwidth*size-1:0]         x_data,
    output logic [inputBitwidth*size*numUnit-1:0] acc_data_in_w_init,
    output logic [logNumCycle-1:0]                acc_w_addr,
    output logic                                  acc_w1_en,
    output logic                                  acc_w2_en,
    output logic                                  acc_start,
    output logic                                  acc_done,
    output logic [inputBitwidth*size-1:0]         acc_data_in_x,
    input  logic                                  acc_x_ce,
    input  logic                                  acc_out_rd,
    input  logic [bitwidth*numUnit-1:0]           acc_data_out,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [bitwidth*numUnit-1:0]           res_data,
    output logic                                  busy,
    output logic                                  ovf
`ifdef AXILINE_FEEDER_OVF_CNT_EN
    ,
    output logic [7:0]                            ovf_cnt
`endif
);

    localparam logic [logNumCycle-1:0] c_LAST_ADDR = logNumCycle'(numCycle - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [logNumCycle-1:0]     r_wcnt;
    logic [logNumCycle-1:0]     r_rcnt;
    logic [15:0]                r_scnt;
    logic [15:0]                r_num;
    logic                       r_start;
    logic                       r_done;
    logic                       r_ovf;
    logic [bitwidth*numUnit-1:0] r_mem [0:1];
    logic                       r_wptr;
    logic                       r_rptr;
    logic [1:0]                 r_cnt;

    logic w_accept, w_w_hs, w_x_hs, w_load_last, w_wrap, w_run_last;
    logic w_push_req, w_pop, w_full, w_push, w_drop;

    assign w_accept    = (r_state == IDLE) && cfg_start && (num_samples != 16'd0);
    assign w_w_hs      = (r_state == LOAD_W) && w_valid;
    assign w_x_hs      = (r_state == RUN) && x_valid && acc_x_ce;
    assign w_load_last = w_w_hs && (r_wcnt == c_LAST_ADDR);
    assign w_wrap      = w_x_hs && (r_rcnt == c_LAST_ADDR);
    assign w_run_last  = w_wrap && ((r_scnt + 16'd1) == r_num);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_req = acc_out_rd && ((r_state == RUN) || (r_state == DRAIN));
    assign w_pop      = res_valid && res_ready;
    assign w_full     = (r_cnt == 2'd2);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        x_ready    = 1'b0;
        acc_w1_en  = 1'b0;
        acc_w2_en  = 1'b0;
        acc_w_addr = '0;
        case (r_state)
            IDLE:   if (w_accept) w_next = LOAD_W;
            LOAD_W: begin
                w_ready    = 1'b1;
                acc_w1_en  = w_valid;
                acc_w_addr = r_wcnt;
                if (w_load_last) w_next = RUN;
            end
            RUN: begin
                x_ready    = acc_x_ce;
                acc_w2_en  = x_valid && acc_x_ce;
                acc_w_addr = r_rcnt;
                if (w_run_last) w_next = DRAIN;
            end
            DRAIN:  if ((r_cnt == 2'd0) && !acc_out_rd) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_scnt  <= '0;
            r_num   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= w_load_last;
            r_done  <= w_run_last;
            if (w_accept) begin
                r_num  <= num_samples;
                r_scnt <= '0;
            end
            if (w_w_hs) r_wcnt <= w_load_last ? '0 : r_wcnt + 1'b1;
            if (w_x_hs) begin
                r_rcnt <= w_wrap ? '0 : r_rcnt + 1'b1;
                if (w_wrap) r_scnt <= r_scnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_accept)    r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= acc_data_out;
    end

`ifdef AXILINE_FEEDER_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end
    assign ovf_cnt = r_ovf_cnt;
`endif

    assign acc_data_in_w_init = w_data;
    assign acc_data_in_x      = x_data;
    assign acc_start          = r_start;
    assign acc_done           = r_done;
    assign res_valid          = (r_cnt != 2'd0);
    assign res_data           = r_mem[r_rptr];
    assign busy               = (r_state != IDLE);
    assign ovf                = r_ovf;

endmodule

`default_nettype wire

// File: doc/axiline_feeder.md
AXILINE_FEEDER -- requirements
Module: axiline_feeder

Interface
REQ-001 SHALL have parameters inputBitwidth (default `INPUT_BITWIDTH), bitwidth (`BITWIDTH), size (`SIZE), numUnit (`NUMBER_UNIT), logNumCycle (`LOG_NUM_CYCLE), numCycle (`NUM_CYCLE).
REQ-002 SHALL have one clock, clk (input, 1), and reset rst (input, 1), synchronous and active-high.
REQ-003 SHALL have these ports:
- cfg_start  in  1  run request pulse.
- num_samples  in  16  samples per run.
- w_valid / w_ready  in / out  1  weight stream handshake.
- w_data  in  inputBitwidth*size*numUnit  weight word.
- x_valid / x_ready  in / out  1  sample stream handshake.
- x_data  in  inputBitwidth*size  sample slice.
REQ-004 SHALL have these accelerator-side ports:
- acc_data_in_w_init  out  inputBitwidth*size*numUnit
- acc_w_addr  out  logNumCycle
- acc_w1_en, acc_w2_en, acc_start, acc_done  out  1 each
- acc_data_in_x  out  inputBitwidth*size
- acc_x_ce, acc_out_rd  in  1 each
- acc_data_out  in  bitwidth*numUnit
REQ-005 SHALL have these result-side ports:
- res_valid  out  1
- res_ready  in  1
- res_data  out  bitwidth*numUnit
- busy  out  1  high when state is not IDLE.
- ovf  out  1  sticky result overflow.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD_W, RUN, DRAIN; busy = (state != IDLE).
REQ-007 IDLE: cfg_start with num_samples != 0 -> LOAD_W. cfg_start with num_samples == 0, or in any other state, SHALL be ignored.
REQ-008 LOAD_W behaviour:
- w_ready = 1.
- acc_w1_en = w_valid & w_ready, combinational.
- acc_data_in_w_init = w_data.
- acc_w_addr = write counter; counter increments per handshake.
- Handshake at address numCycle-1 -> RUN, write counter cleared.
REQ-009 SHALL assert acc_start for exactly the first cycle in RUN.
REQ-010 RUN behaviour:
- x_ready = acc_x_ce.
- acc_data_in_x = x_data.
- acc_w2_en = x_valid & acc_x_ce.
- acc_w_addr = read counter.
REQ-011 RUN stall: if x_valid is low, the read counter and sample counter SHALL hold and acc_w2_en SHALL be 0.
REQ-012 Read counter SHALL increment per x handshake and wrap numCycle-1 -> 0; each wrap SHALL increment the 16-bit sample counter.
REQ-013 On the wrap that makes the sample counter equal num_samples (latched at cfg_start), SHALL pulse acc_done for 1 cycle and enter DRAIN.
REQ-014 DRAIN SHALL return to IDLE in the cycle after the result FIFO is empty and acc_out_rd is low.
REQ-015 Result FIFO:
- 2 entries, capturing acc_data_out on every acc_out_rd in RUN or DRAIN.
- res_valid = FIFO not empty; res_data = head entry; pop on res_valid & res_ready.
- Capture-to-res_valid latency: 1 cycle.
REQ-016 FIFO boundary cases:
- Simultaneous push and pop when full SHALL succeed, with no overflow.
- Push when full without pop SHALL drop the data and set ovf; ovf clears only on reset or the next accepted cfg_start.
REQ-017 Outside the states named in REQ-008 and REQ-010, w_ready, x_ready, acc_w1_en and acc_w2_en SHALL be 0, and acc_w_addr SHALL be 0.

Reset
REQ-018 rst SHALL, in any state including mid-run, force:
- state to IDLE;
- all counters, FIFO pointers, ovf, acc_start and acc_done to 0;
- res_valid = 0 and busy = 0 in the following cycle.

Configuration
REQ-019 Macro AXILINE_FEEDER_OVF_CNT_EN defined: SHALL add output ovf_cnt (8-bit), which counts dropped results, saturates at 255, and clears with ovf. Macro undefined: port and counter absent; all other behaviour is identical.

Verification (numCycle=4)
REQ-020 cfg_start, num_samples=2, 4 weight words W0..W3 back to back -> acc_w1_en high 4 cycles at addr 0,1,2,3, then acc_start pulses once.
REQ-021 RUN with acc_x_ce=1, 8 x beats with x_valid low for 2 cycles after beat 3 -> addr sequence 0,1,2,3,0,1,2,3 with a hold at 3 during the stall, then acc_done pulses once after beat 8.
REQ-022 3 acc_out_rd pulses with res_ready=0 -> first 2 results retained in order, ovf=1, ovf_cnt=1 when enabled.
REQ-023 FIFO full, acc_out_rd and res_ready in the same cycle -> head popped, new word enqueued, ovf stays 0.
REQ-024 rst asserted mid-RUN at addr 2 -> next cycle busy=0, acc_w_addr=0, res_valid=0; a new cfg_start with num_samples=1 completes normally.
REQ-025 cfg_start with num_samples=0, and cfg_start during RUN -> both ignored: no state change, no acc_start.
